// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-capturing interrupt controller with enable mask, claim/complete handshake; IRQ_CTRL_SYNC_EN adds a two-flop input synchronizer
module irq_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             i_CLK,
  input  logic             i_RSTn,
  input  logic [N_SRC-1:0] i_IRQ,
  input  logic             i_CE,
  input  logic             i_REQ,
  input  logic             i_WE,
  input  logic [1:0]       i_ADDR,
  input  logic [31:0]      i_WDATA,
  output logic             o_GNT,
  output logic [31:0]      o_RDATA,
  output logic             o_EXT_IRQ
);
  typedef enum logic {IDLE, SERVICE} state_t;
  state_t state;
  logic [N_SRC-1:0] pending, enable, irq_q, irq_in, set, clr;
  logic [4:0] id, best;
  logic acc, claim_ok, complete;
`ifdef IRQ_CTRL_SYNC_EN
  logic [N_SRC-1:0] sync1, sync2;
  // two-flop synchronizer so asynchronous sources are safe to edge-detect
  always_ff @(posedge i_CLK or negedge i_RSTn)
    if (!i_RSTn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_IRQ;
      sync2 <= sync1;
    end
  assign irq_in = sync2;
`else
  assign irq_in = i_IRQ;
`endif
  assign acc      = i_REQ & i_CE;
  assign o_GNT    = acc;
  assign claim_ok = acc & ~i_WE & (i_ADDR == 2'd2) & (state == IDLE) & (best != 5'd0);
  assign complete = acc & i_WE & (i_ADDR == 2'd2) & (state == SERVICE) & (i_WDATA[4:0] == id);
  assign set      = irq_in & ~irq_q;
  assign clr      = ((acc & i_WE & (i_ADDR == 2'd0)) ? i_WDATA[N_SRC-1:0] : '0) |
                    (claim_ok ? N_SRC'(1) << (best - 5'd1) : '0);
  // best id: lowest enabled pending source, reported one-based
  always_comb begin
    best = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (pending[i] & enable[i]) best = 5'(i + 1);
  end
  // register read mux; a claim read in service reports no source
  always_comb
    o_RDATA = (i_ADDR == 2'd0) ? 32'(pending) :
              (i_ADDR == 2'd1) ? 32'(enable) :
              (i_ADDR == 2'd2) ? ((state == IDLE) ? 32'(best) : 32'd0) :
              {19'd0, id, 7'd0, state == SERVICE};
  // pending capture, enable register, claim/complete FSM and request output
  always_ff @(posedge i_CLK or negedge i_RSTn)
    if (!i_RSTn) begin
      state     <= IDLE;
      id        <= '0;
      pending   <= '0;
      enable    <= '0;
      irq_q     <= '0;
      o_EXT_IRQ <= 1'b0;
    end else begin
      irq_q     <= irq_in;
      pending   <= (pending & ~clr) | set;
      o_EXT_IRQ <= (state == IDLE) & ~claim_ok & |(pending & enable);
      if (acc & i_WE & (i_ADDR == 2'd1)) enable <= i_WDATA[N_SRC-1:0];
      if (claim_ok) begin
        state <= SERVICE;
        id    <= best;
      end else if (complete) begin
        state <= IDLE;
        id    <= '0;
      end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed vector table plus reset and latency sequences for irq_ctrl
module tb_irq_ctrl;
  logic clk = 0, rst_n = 0, ce = 0, req = 0, we = 0, gnt, ext;
  logic [7:0] irq = '0;
  logic [1:0] addr = '0;
  logic [31:0] wdata = '0, rdata;
  int total = 0, bad = 0;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  irq_ctrl #(.N_SRC(8)) dut (
    .i_CLK(clk), .i_RSTn(rst_n), .i_IRQ(irq), .i_CE(ce), .i_REQ(req), .i_WE(we),
    .i_ADDR(addr), .i_WDATA(wdata), .o_GNT(gnt), .o_RDATA(rdata), .o_EXT_IRQ(ext)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  irq;
    logic        ce;
    logic        req;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] rd;
    logic        ext;
  } vec_t;
  vec_t v[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic add_rd(input logic [1:0] a, input logic [7:0] i, input logic [31:0] e, input logic x);
    v.push_back('{i, 1'b1, 1'b1, 1'b0, a, 32'd0, 1'b1, e, x});
  endtask

  task automatic add_wr(input logic [1:0] a, input logic [31:0] d, input logic [7:0] i, input logic x);
    v.push_back('{i, 1'b1, 1'b1, 1'b1, a, d, 1'b0, 32'd0, x});
  endtask

  task automatic add_nop(input logic [7:0] i, input logic x);
    v.push_back('{i, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, x});
  endtask

  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d);
    ce = 1; req = 1; we = w; addr = a; wdata = d;
  endtask

  initial begin
    int lat;
    // pulse on source 3 with only it enabled, claim and complete
    add_wr(2'd1, 32'h08, 8'h00, 0);
    add_nop(8'h08, 0);
    add_rd(2'd0, 8'h00, 32'h08, 1);
    add_rd(2'd2, 8'h00, 32'd4, 0);
    add_rd(2'd3, 8'h00, 32'h0401, 0);
    add_wr(2'd2, 32'd4, 8'h00, 0);
    add_rd(2'd3, 8'h00, 32'h0, 0);
    // simultaneous sources 5 and 1, priority and service-state rules
    add_wr(2'd1, 32'hFF, 8'h00, 0);
    add_nop(8'h22, 0);
    add_rd(2'd0, 8'h00, 32'h22, 1);
    add_rd(2'd2, 8'h00, 32'd2, 0);
    add_rd(2'd2, 8'h00, 32'd0, 0);
    add_wr(2'd2, 32'd5, 8'h00, 0);
    add_rd(2'd3, 8'h00, 32'h0201, 0);
    add_wr(2'd2, 32'd2, 8'h00, 0);
    add_rd(2'd3, 8'h00, 32'h0, 1);
    add_rd(2'd2, 8'h00, 32'd6, 0);
    add_wr(2'd2, 32'd6, 8'h00, 0);
    // disabled source accumulates, late enable, set beats W1C
    add_wr(2'd1, 32'h00, 8'h00, 0);
    add_nop(8'h01, 0);
    add_rd(2'd0, 8'h00, 32'h01, 0);
    add_wr(2'd1, 32'h01, 8'h00, 0);
    add_rd(2'd1, 8'h00, 32'h01, 1);
    add_wr(2'd0, 32'h01, 8'h01, 1);
    add_rd(2'd0, 8'h01, 32'h01, 1);
    add_wr(2'd0, 32'h01, 8'h00, 1);
    add_rd(2'd0, 8'h00, 32'h00, 0);
    // new edge during a claim of the same source keeps it pending
    add_nop(8'h01, 0);
    add_rd(2'd0, 8'h00, 32'h01, 1);
    add_rd(2'd2, 8'h01, 32'd1, 0);
    add_rd(2'd0, 8'h00, 32'h01, 0);
    add_rd(2'd2, 8'h00, 32'd0, 0);
    add_wr(2'd2, 32'd1, 8'h00, 0);
    add_rd(2'd3, 8'h00, 32'h0, 1);
    add_rd(2'd2, 8'h00, 32'd1, 0);
    // STATUS read-only, bits above N_SRC read 0, CE gates accesses
    add_wr(2'd3, 32'hFFFF_FFFF, 8'h00, 0);
    add_rd(2'd3, 8'h00, 32'h0101, 0);
    add_wr(2'd1, 32'hFFFF_FFFF, 8'h00, 0);
    add_rd(2'd1, 8'h00, 32'hFF, 0);
    v.push_back('{8'h00, 1'b0, 1'b1, 1'b1, 2'd2, 32'd1, 1'b0, 32'd0, 1'b0});
    add_rd(2'd3, 8'h00, 32'h0101, 0);

    // reset state
    #2;
    check("rst ext", 32'(ext), 32'd0);
    for (int a = 0; a < 4; a++) begin
      bus(0, 2'(a), 0);
      #1 check($sformatf("rst rdata%0d", a), rdata, 32'd0);
    end
    req = 0;
    @(negedge clk) rst_n = 1;

    foreach (v[n]) begin
      @(negedge clk);
      irq = v[n].irq; ce = v[n].ce; req = v[n].req; we = v[n].we; addr = v[n].addr; wdata = v[n].wdata;
      #1;
      check($sformatf("v%0d gnt", n), 32'(gnt), 32'(v[n].ce & v[n].req));
      if (v[n].chk) check($sformatf("v%0d rdata", n), rdata, v[n].rd);
      @(posedge clk);
      #1 check($sformatf("v%0d ext", n), 32'(ext), 32'(v[n].ext));
    end

    // asynchronous reset between edges while in service
    @(negedge clk);
    req = 0; irq = 8'h04;
    @(posedge clk);
    #1 irq = 0;
    @(negedge clk);
    bus(0, 2'd3, 0);
    #1 check("pre-rst status", rdata, 32'h0101);
    #2 rst_n = 0;
    #1 check("mid-rst ext", 32'(ext), 32'd0);
    check("mid-rst status", rdata, 32'd0);
    addr = 2'd0;
    #1 check("mid-rst pending", rdata, 32'd0);
    addr = 2'd1;
    #1 check("mid-rst enable", rdata, 32'd0);
    req = 0;
    @(negedge clk) rst_n = 1;

    // pulse-to-request latency
    @(negedge clk) bus(1, 2'd1, 32'h01);
    @(negedge clk);
    req = 0; irq = 8'h01; lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) irq = 0;
      if (ext) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'(LAT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
